// File: rtl/capture_pkg.sv
// capture_pkg: shared FSM state type, default address width and RGB332 helpers
// for the frame capture writer (bayer table and saturating add serve the dither build).
package capture_pkg;

  localparam int CAP_AW = 17;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } cap_state_t;

  // 2x2 ordered dither offsets, indexed by k = {v[0], h[0]}:
  // k0->0, k1->2, k2->3, k3->1
  localparam logic [7:0] BAYER_M = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] bayer_m(
    input logic [1:0] k
  );
    return BAYER_M[{k, 1'b0} +: 2];
  endfunction

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] d
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, d};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] pack_rgb332(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/rgb332_packer.sv
// rgb332_packer: registered RGB888 -> RGB332, 1-clk latency (clk, reset, r/g/b in,
// rgb332 out; bayer_k = {v[0],h[0]} only when CAPTURE_DITHER_EN is defined).
module rgb332_packer
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
`ifdef CAPTURE_DITHER_EN
  input  logic [1:0] bayer_k,
`endif
  output logic [7:0] rgb332
);

  logic [7:0] r_d;
  logic [7:0] g_d;
  logic [7:0] b_d;

`ifdef CAPTURE_DITHER_EN
  logic [1:0] m;

  // offset is scaled to one LSB of the kept field:
  // 3-bit r/g fields step by 32 (m*8), 2-bit b by 64 (m*16)
  always_comb begin
    m   = bayer_m(bayer_k);
    r_d = sat_add(r, {3'd0, m, 3'd0});
    g_d = sat_add(g, {3'd0, m, 3'd0});
    b_d = sat_add(b, {2'd0, m, 4'd0});
  end
`else
  always_comb begin
    r_d = r;
    g_d = g;
    b_d = b;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb332 <= '0;
    end else begin
      rgb332 <= pack_rgb332(r_d, g_d, b_d);
    end
  end

endmodule

// File: rtl/framebuffer_capture.sv
// framebuffer_capture: grabs one full frame of RGB888 video on capture_req and
// emits a linear RGB332 write stream (wr_en/wr_addr/wr_data) into a 2**AW x 8 RAM.
// Inputs: clk, reset, ce_pix, h/v counters, visible/front-porch geometry, r/g/b,
// capture_req. Outputs: wr_en, wr_addr, wr_data, busy, done (pulse), overflow (sticky).
// Optional CAPTURE_DITHER_EN enables 2x2 ordered dither in the packer.
module framebuffer_capture
  import capture_pkg::*;
#(
  parameter int AW = CAP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  input  logic [9:0]    h_visible_dots,
  input  logic [9:0]    v_visible_lines,
  input  logic [5:0]    h_front_porch_dots,
  input  logic [5:0]    v_front_porch_lines,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic          capture_req,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  cap_state_t  state;
  // one bit wider than the address: idx[AW] means DEPTH reached
  logic [AW:0] idx;

  logic [9:0] h_sync_pos;
  logic [9:0] v_sync_pos;
  logic       visible;
  logic       frame_sync;
  logic       last_px;

  always_comb begin
    h_sync_pos = h_visible_dots + {4'd0, h_front_porch_dots};
    v_sync_pos = v_visible_lines + {4'd0, v_front_porch_lines};
    visible    = ce_pix
              && (h_count < h_visible_dots)
              && (v_count < v_visible_lines);
    frame_sync = ce_pix
              && (h_count == h_sync_pos)
              && (v_count == v_sync_pos);
    last_px    = visible
              && (h_count == h_visible_dots - 10'd1)
              && (v_count == v_visible_lines - 10'd1);
  end

  // data path runs every clk; its 1-clk latency lines up
  // with the registered strobe/address below
  rgb332_packer u_pack (
    .clk     (clk),
    .reset   (reset),
    .r       (r),
    .g       (g),
    .b       (b),
`ifdef CAPTURE_DITHER_EN
    .bayer_k ({v_count[0], h_count[0]}),
`endif
    .rgb332  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_req) begin
            state    <= ARMED;
            busy     <= 1'b1;
            idx      <= '0;
            overflow <= 1'b0;
          end
        end
        ARMED: begin
          // wait for blanking so a partial frame is never taken
          if (frame_sync) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (visible) begin
            if (!idx[AW]) begin
              wr_en   <= 1'b1;
              wr_addr <= idx[AW-1:0];
              idx     <= idx + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (last_px) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_capture.sv
// tb_framebuffer_capture: table-driven capture runs on small geometries plus
// directed sequences (mid-frame req, req while busy, req on frame_sync, reset).
`timescale 1ns/1ps
module tb_framebuffer_capture;

  localparam int AW = 8;

`ifdef CAPTURE_DITHER_EN
  localparam logic [7:0] CONST_LAST = 8'hE7;
`else
  localparam logic [7:0] CONST_LAST = 8'hE3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix = 1'b0;
  logic [9:0]    h_count = '0;
  logic [9:0]    v_count = '0;
  logic [9:0]    h_visible_dots = 10'd16;
  logic [9:0]    v_visible_lines = 10'd8;
  logic [5:0]    h_front_porch_dots = 6'd2;
  logic [5:0]    v_front_porch_lines = 6'd1;
  logic [7:0]    r = '0;
  logic [7:0]    g = '0;
  logic [7:0]    b = '0;
  logic          capture_req = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          overflow;

  framebuffer_capture #(.AW(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ce_pix              (ce_pix),
    .h_count             (h_count),
    .v_count             (v_count),
    .h_visible_dots      (h_visible_dots),
    .v_visible_lines     (v_visible_lines),
    .h_front_porch_dots  (h_front_porch_dots),
    .v_front_porch_lines (v_front_porch_lines),
    .r                   (r),
    .g                   (g),
    .b                   (b),
    .capture_req         (capture_req),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .busy                (busy),
    .done                (done),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int h_tot = 22;
  int v_tot = 11;
  int ce_div = 4;
  int gen_mode = 0;
  int gen_epoch = 0;
  int seen_epoch = 0;
  int div_cnt = 0;

  function automatic logic [23:0] pixel(input int mode, input int h, input int v);
    logic [7:0] pr, pg, pb;
    case (mode)
      1: begin pr = 8'hE0; pg = 8'h1C; pb = 8'hC0; end
      2: begin pr = 8'hF0; pg = 8'h1C; pb = 8'hC0; end
      default: begin
        pr = 8'(h * 13 + v * 7);
        pg = 8'((h * 5) ^ (v * 29));
        pb = 8'(h + v * 37);
      end
    endcase
    return {pr, pg, pb};
  endfunction

  // video timing source: counters advance after each ce_pix cycle
  always @(negedge clk) begin
    if (seen_epoch != gen_epoch) begin
      seen_epoch = gen_epoch;
      h_count = '0;
      v_count = '0;
      div_cnt = 0;
      ce_pix = 1'b0;
    end else begin
      if (ce_pix) begin
        if (int'(h_count) == h_tot - 1) begin
          h_count = '0;
          if (int'(v_count) == v_tot - 1) v_count = '0;
          else v_count = v_count + 10'd1;
        end else begin
          h_count = h_count + 10'd1;
        end
      end
      div_cnt = (div_cnt + 1) % ce_div;
      ce_pix = (div_cnt == 0);
    end
    {r, g, b} = pixel(gen_mode, int'(h_count), int'(v_count));
  end

  // reference pack for capture pixel number 'addr' (capture starts at (0,0))
  function automatic logic [7:0] exp_data(input int addr);
    int h, v, rr, gg, bb, m;
    logic [23:0] p;
    h = addr % int'(h_visible_dots);
    v = addr / int'(h_visible_dots);
    p = pixel(gen_mode, h, v);
    rr = int'(p[23:16]);
    gg = int'(p[15:8]);
    bb = int'(p[7:0]);
    m = 0;
`ifdef CAPTURE_DITHER_EN
    case ({v[0], h[0]})
      2'd0: m = 0;
      2'd1: m = 2;
      2'd2: m = 3;
      default: m = 1;
    endcase
    rr = rr + m * 8;  if (rr > 255) rr = 255;
    gg = gg + m * 8;  if (gg > 255) gg = 255;
    bb = bb + m * 16; if (bb > 255) bb = 255;
`endif
    return {rr[7:5], gg[7:5], bb[7:6]} + 8'(m * 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int wr_cnt = 0;
  int done_cnt = 0;
  int done_with_wr = 0;
  int sync_cnt = 0;
  int first_sync = -1;
  bit sync_now = 1'b0;
  logic [7:0] last_data = '0;

  // one clock: outputs checked at negedge+1, away from posedge
  task automatic tick();
    @(negedge clk);
    #1;
    sync_now = ce_pix
      && (h_count == h_visible_dots + {4'd0, h_front_porch_dots})
      && (v_count == v_visible_lines + {4'd0, v_front_porch_lines});
    if (sync_now) sync_cnt++;
    if (wr_en === 1'b1) begin
      if (wr_cnt == 0) first_sync = sync_cnt;
      chk("wr_addr", 32'(wr_addr), 32'(wr_cnt % (1 << AW)));
      chk("wr_data", 32'(wr_data), 32'(exp_data(wr_cnt)));
      last_data = wr_data;
      wr_cnt++;
      if (done === 1'b1) done_with_wr++;
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic set_geom(input int hv, input int vv, input int hf,
                          input int vf, input int dv, input int md);
    h_visible_dots = 10'(hv);
    v_visible_lines = 10'(vv);
    h_front_porch_dots = 6'(hf);
    v_front_porch_lines = 6'(vf);
    h_tot = hv + hf + 4;
    v_tot = vv + vf + 2;
    ce_div = dv;
    gen_mode = md;
    gen_epoch++;
    repeat (3) tick();
  endtask

  task automatic clr_counts();
    wr_cnt = 0;
    done_cnt = 0;
    done_with_wr = 0;
    first_sync = -1;
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  typedef struct {
    int hv, vv, hf, vf, dv, md;
    int exp_wr;
    bit exp_ovf;
    bit chk_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, s;

    tbl[0] = '{16, 8, 2, 1, 4, 0, 128, 1'b0, 1'b0};
    tbl[1] = '{16, 8, 2, 1, 4, 1, 128, 1'b0, 1'b1};
    tbl[2] = '{20, 6, 3, 2, 4, 2, 120, 1'b0, 1'b1};
    tbl[3] = '{32, 8, 4, 2, 1, 0, 256, 1'b0, 1'b0};
    tbl[4] = '{32, 12, 4, 2, 1, 0, 256, 1'b1, 1'b0};

    reset = 1'b1;
    repeat (4) tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      set_geom(tbl[i].hv, tbl[i].vv, tbl[i].hf, tbl[i].vf, tbl[i].dv, tbl[i].md);
      clr_counts();
      pulse_req();
      chk("busy_after_req", 32'(busy), 32'd1);
      wait_done(6000);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("writes", 32'(wr_cnt), 32'(tbl[i].exp_wr));
      chk("overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
      chk("done_with_last_wr", 32'(done_with_wr), 32'(!tbl[i].exp_ovf));
      if (tbl[i].chk_last) chk("const_pixel", 32'(last_data), 32'(CONST_LAST));
      repeat (60) tick();
      chk("done_once", 32'(done_cnt), 32'd1);
    end

    // req mid-frame: overflow still sticky, cleared by req, capture from next frame
    set_geom(16, 8, 2, 1, 4, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    n = 0;
    while (!(v_count == 10'd4 && h_count == 10'd3) && n < 3000) begin
      tick();
      n++;
    end
    chk("midframe_reach", 32'(n < 3000), 32'd1);
    s = sync_cnt;
    clr_counts();
    pulse_req();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    wait_done(4000);
    chk("midframe_first_sync", 32'(first_sync), 32'(s + 1));
    chk("midframe_writes", 32'(wr_cnt), 32'd128);

    // req while ARMED and while CAPTURE is ignored
    repeat (5) tick();
    clr_counts();
    pulse_req();
    repeat (3) tick();
    pulse_req();
    n = 0;
    while (wr_cnt < 20 && n < 3000) begin
      tick();
      n++;
    end
    pulse_req();
    wait_done(4000);
    chk("busy_req_writes", 32'(wr_cnt), 32'd128);
    repeat (1200) tick();
    chk("busy_req_idle", 32'(busy), 32'd0);
    chk("busy_req_done", 32'(done_cnt), 32'd1);
    chk("busy_req_no_extra", 32'(wr_cnt), 32'd128);

    // req coincident with frame_sync: capture starts one frame later
    n = 0;
    tick();
    while (!sync_now && n < 3000) begin
      tick();
      n++;
    end
    s = sync_cnt;
    clr_counts();
    pulse_req();
    chk("coinc_armed", 32'(busy), 32'd1);
    wait_done(4000);
    chk("coinc_first_sync", 32'(first_sync), 32'(s + 1));
    chk("coinc_writes", 32'(wr_cnt), 32'd128);

    // reset mid-capture
    repeat (5) tick();
    clr_counts();
    pulse_req();
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr == 8'd50) && n < 4000) begin
      tick();
      n++;
    end
    chk("rst_mid_reach", 32'(n < 4000), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_addr", 32'(wr_addr), 32'd0);
    reset = 1'b0;
    clr_counts();
    repeat (2500) tick();
    chk("rst_mid_quiet", 32'(wr_cnt), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    clr_counts();
    pulse_req();
    wait_done(4000);
    chk("rst_mid_recap", 32'(wr_cnt), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
